regfile_wb_ctrl: RTL

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller.
// Merges ALU results (strict priority) with a small in-order load-writeback
// FIFO into one registered register-file write port. After reset it walks
// every register except ZERO_REG and clears it before accepting ALU traffic.
// The registered write port doubles as the forwarding source for two read
// ports; entries still waiting in the FIFO are never forwarded.
module regfile_wb_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ZERO_REG   = 31
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [63:0] alu_data,

  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_addr,
  input  logic [63:0] ld_data,

  output logic        write,
  output logic [4:0]  wrAddr,
  output logic [63:0] wrData,

  input  logic [4:0]  rdAddrA,
  input  logic [4:0]  rdAddrB,
  output logic        fwdA_hit,
  output logic        fwdB_hit,

  output logic        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);
  // The clear walk always spans the full 5-bit space; the zero register is
  // simply skipped when the counter passes it.
  localparam logic [4:0] LAST_IDX = 5'd31;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t stateReg, stateNext;
  logic [4:0] initCntReg, initCntNext;

  logic        writeReg, writeNext;
  logic [4:0]  wrAddrReg, wrAddrNext;
  logic [63:0] wrDataReg, wrDataNext;

  // Load FIFO storage and bookkeeping
  logic [4:0]  addrMem [FIFO_DEPTH];
  logic [63:0] dataMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
  logic [CNT_W-1:0] countReg, countNext;

  logic full, empty;
  logic aluBeat, ldBeat, popHead;
  logic [4:0]  headAddr;
  logic [63:0] headData;

  assign full     = (countReg == CNT_W'(FIFO_DEPTH));
  assign empty    = (countReg == '0);
  // Full is judged on the occupancy before any same-cycle pop, so a full
  // FIFO never accepts a load even while it is draining.
  assign ld_ready = !full;
  assign ldBeat   = ld_valid && ld_ready;
  assign aluBeat  = alu_valid && alu_ready;
  assign popHead  = (stateReg == RUN) && !aluBeat && !empty;
  assign headAddr = addrMem[rdPtrReg];
  assign headData = dataMem[rdPtrReg];

  assign write      = writeReg;
  assign wrAddr     = wrAddrReg;
  assign wrData     = wrDataReg;
  assign fifo_count = countReg;

  // FSM next state, clear counter and handshake outputs
  always_comb begin
    stateNext   = stateReg;
    initCntNext = initCntReg;
    alu_ready   = 1'b0;
    busy        = 1'b0;
    case (stateReg)
      INIT: begin
        busy        = 1'b1;
        initCntNext = initCntReg + 5'd1;
        if (initCntReg == LAST_IDX) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        alu_ready = 1'b1;
      end
      default: begin
        stateNext = INIT;
      end
    endcase
  end

  // Writeback source selection: clear walk, then ALU, then FIFO head
  always_comb begin
    writeNext  = 1'b0;
    wrAddrNext = wrAddrReg;
    wrDataNext = wrDataReg;
    if (stateReg == INIT) begin
      if (initCntReg != ZERO_IDX) begin
        writeNext  = 1'b1;
        wrAddrNext = initCntReg;
        wrDataNext = '0;
      end
    end else if (aluBeat) begin
      // A zero-register request is consumed but produces no write.
      writeNext  = (alu_addr != ZERO_IDX);
      wrAddrNext = alu_addr;
      wrDataNext = alu_data;
    end else if (popHead) begin
      writeNext  = (headAddr != ZERO_IDX);
      wrAddrNext = headAddr;
      wrDataNext = headData;
    end
  end

  // FIFO occupancy: simultaneous push and pop cancel out
  always_comb begin
    countNext = countReg;
    case ({ldBeat, popHead})
      2'b10:   countNext = countReg + CNT_W'(1);
      2'b01:   countNext = countReg - CNT_W'(1);
      default: countNext = countReg;
    endcase
  end

  // State, write port and FIFO pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg   <= INIT;
      initCntReg <= '0;
      writeReg   <= 1'b0;
      wrAddrReg  <= '0;
      wrDataReg  <= '0;
      wrPtrReg   <= '0;
      rdPtrReg   <= '0;
      countReg   <= '0;
    end else begin
      stateReg   <= stateNext;
      initCntReg <= initCntNext;
      writeReg   <= writeNext;
      wrAddrReg  <= wrAddrNext;
      wrDataReg  <= wrDataNext;
      countReg   <= countNext;
      // Pointers are exactly log2(depth) bits wide, so they wrap naturally.
      if (ldBeat) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (popHead) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are meaningless until pointed at, so no reset
  always_ff @(posedge clk) begin
    if (ldBeat) begin
      addrMem[wrPtrReg] <= ld_addr;
      dataMem[wrPtrReg] <= ld_data;
    end
  end

  // Forwarding compare, one instance per read port
  logic [4:0] rdAddr [2];
  logic [1:0] fwdHit;
  assign rdAddr[0] = rdAddrA;
  assign rdAddr[1] = rdAddrB;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwdHit[gi] = writeReg && (rdAddr[gi] == wrAddrReg) &&
                          (wrAddrReg != ZERO_IDX);
    end
  endgenerate

  assign fwdA_hit = fwdHit[0];
  assign fwdB_hit = fwdHit[1];

endmodule
